snitch_acc_share_arbiter: RTL and testbench

SNITCH_ACC_SHARE_ARBITER -- requirements
Module: snitch_acc_share_arbiter

---
 rtl/snitch_acc_share_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_snitch_acc_share_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snitch_acc_share_arbiter.sv
// rtl/snitch_acc_share_arbiter.sv - round-robin sharing of one offload unit among several cores
//
// Purpose: arbitrates per-core offload requests onto a single shared unit through a
// one-entry output register, tracks in-flight offloads per core with credit counters,
// and routes responses back by the source index the unit echoes.
//
// Ports:
//   clk_i, rst_i                    clock, synchronous active-high reset
//   core_qvalid_i/qready_o/qdata_i  per-core request channel (qready_o is the grant)
//   acc_qvalid_o/qready_i/qdata_o   registered request towards the shared unit
//   acc_qsrc_o                      originating core of the registered request
//   acc_pvalid_i/pready_o/pdata_i   response from the shared unit
//   acc_psrc_i                      core index echoed with the response
//   core_pvalid_o/pready_i/pdata_o  per-core response channel (data broadcast)
//   err_o                           sticky protocol-violation flag
module snitch_acc_share_arbiter #(
    parameter int unsigned NrCores        = 4,
    parameter int unsigned MaxOutstanding = 2,
    parameter int unsigned ReqW           = 165,
    parameter int unsigned RspW           = 38,
    localparam int unsigned IdxW          = $clog2(NrCores)
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [NrCores-1:0]               core_qvalid_i,
    output logic [NrCores-1:0]               core_qready_o,
    input  logic [NrCores-1:0][ReqW-1:0]     core_qdata_i,
    output logic                             acc_qvalid_o,
    input  logic                             acc_qready_i,
    output logic [ReqW-1:0]                  acc_qdata_o,
    output logic [IdxW-1:0]                  acc_qsrc_o,
    input  logic                             acc_pvalid_i,
    output logic                             acc_pready_o,
    input  logic [RspW-1:0]                  acc_pdata_i,
    input  logic [IdxW-1:0]                  acc_psrc_i,
    output logic [NrCores-1:0]               core_pvalid_o,
    input  logic [NrCores-1:0]               core_pready_i,
    output logic [NrCores-1:0][RspW-1:0]     core_pdata_o,
    output logic                             err_o
);

    localparam int unsigned     CntW   = $clog2(MaxOutstanding + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(MaxOutstanding);

    // State
    logic [NrCores-1:0][CntW-1:0] credit;
    logic [IdxW-1:0]              last_grant;
    logic                         q_valid;
    logic [ReqW-1:0]              q_data;
    logic [IdxW-1:0]              q_src;
    logic                         err;

    // Request-side combinational signals
    logic [NrCores-1:0] eligible;
    logic [NrCores-1:0] grant;
    logic               out_free;
    logic               hi_found;
    logic               lo_found;
    logic [IdxW-1:0]    hi_idx;
    logic [IdxW-1:0]    lo_idx;
    logic               win_found;
    logic [IdxW-1:0]    win_idx;
    logic [ReqW-1:0]    win_data;

    // Response-side combinational signals
    logic               src_ok;
    logic               pready_sel;
    logic [NrCores-1:0] rsp_hs;
    logic [NrCores-1:0] rsp_unsolicited;

    assign acc_qvalid_o = q_valid;
    assign acc_qdata_o  = q_data;
    assign acc_qsrc_o   = q_src;
    assign err_o        = err;

    // The output register can take a new entry when empty or when its entry leaves now.
    assign out_free = !q_valid || acc_qready_i;

    always_comb begin
        eligible = '0;
        for (int k = 0; k < NrCores; k++) begin
            eligible[k] = core_qvalid_i[k] && (credit[k] < CntMax);
        end
    end

    // Round robin as two priority scans: the first eligible core above last_grant wins;
    // if there is none, the search wraps to the lowest eligible index.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int k = 0; k < NrCores; k++) begin
            if (eligible[k] && !hi_found && (IdxW'(k) > last_grant)) begin
                hi_found = 1'b1;
                hi_idx   = IdxW'(k);
            end
            if (eligible[k] && !lo_found) begin
                lo_found = 1'b1;
                lo_idx   = IdxW'(k);
            end
        end
    end

    assign win_found = hi_found || lo_found;
    assign win_idx   = hi_found ? hi_idx : lo_idx;

    always_comb begin
        grant    = '0;
        win_data = '0;
        for (int k = 0; k < NrCores; k++) begin
            if (win_idx == IdxW'(k)) begin
                grant[k] = !rst_i && out_free && win_found;
                win_data = core_qdata_i[k];
            end
        end
    end

    assign core_qready_o = grant;

    // Response routing; an index with no matching core is swallowed (pready forced high).
    always_comb begin
        src_ok        = 1'b0;
        pready_sel    = 1'b0;
        core_pvalid_o = '0;
        core_pdata_o  = '0;
        for (int k = 0; k < NrCores; k++) begin
            core_pvalid_o[k] = acc_pvalid_i && (acc_psrc_i == IdxW'(k));
            core_pdata_o[k]  = acc_pdata_i;
            if (acc_psrc_i == IdxW'(k)) begin
                src_ok     = 1'b1;
                pready_sel = core_pready_i[k];
            end
        end
        acc_pready_o = src_ok ? pready_sel : 1'b1;
    end

    always_comb begin
        rsp_hs          = '0;
        rsp_unsolicited = '0;
        for (int k = 0; k < NrCores; k++) begin
            rsp_hs[k]          = core_pvalid_o[k] && core_pready_i[k];
            rsp_unsolicited[k] = rsp_hs[k] && (credit[k] == '0);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q_valid    <= 1'b0;
            q_data     <= '0;
            q_src      <= '0;
            last_grant <= IdxW'(NrCores - 1);
            credit     <= '0;
            err        <= 1'b0;
        end else begin
            if (|grant) begin
                q_valid    <= 1'b1;
                q_data     <= win_data;
                q_src      <= win_idx;
                last_grant <= win_idx;
            end else if (acc_qready_i) begin
                q_valid <= 1'b0;
            end

            for (int k = 0; k < NrCores; k++) begin
                case ({grant[k], rsp_hs[k]})
                    2'b10: credit[k] <= credit[k] + 1'b1;
                    2'b01: begin
                        if (credit[k] != '0) begin
                            credit[k] <= credit[k] - 1'b1;
                        end
                    end
                    // A response arriving with the grant belongs to an older offload,
                    // so it cancels the increment unless nothing was outstanding.
                    2'b11: begin
                        if (credit[k] == '0) begin
                            credit[k] <= credit[k] + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end

            if ((acc_pvalid_i && !src_ok) || (|rsp_unsolicited)) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_snitch_acc_share_arbiter.sv
// tb/tb_snitch_acc_share_arbiter.sv - directed bench for snitch_acc_share_arbiter
module tb_snitch_acc_share_arbiter;

    logic                 clk;
    logic                 rst;

    logic [3:0]           core_qvalid;
    logic [3:0]           core_qready;
    logic [3:0][164:0]    core_qdata;
    logic                 acc_qvalid;
    logic                 acc_qready;
    logic [164:0]         acc_qdata;
    logic [1:0]           acc_qsrc;
    logic                 acc_pvalid;
    logic                 acc_pready;
    logic [37:0]          acc_pdata;
    logic [1:0]           acc_psrc;
    logic [3:0]           core_pvalid;
    logic [3:0]           core_pready;
    logic [3:0][37:0]     core_pdata;
    logic                 err;

    logic [4:0]           x_core_qvalid;
    logic [4:0]           x_core_qready;
    logic [4:0][164:0]    x_core_qdata;
    logic                 x_acc_qvalid;
    logic                 x_acc_qready;
    logic [164:0]         x_acc_qdata;
    logic [2:0]           x_acc_qsrc;
    logic                 x_acc_pvalid;
    logic                 x_acc_pready;
    logic [37:0]          x_acc_pdata;
    logic [2:0]           x_acc_psrc;
    logic [4:0]           x_core_pvalid;
    logic [4:0]           x_core_pready;
    logic [4:0][37:0]     x_core_pdata;
    logic                 x_err;

    int n_cmp = 0;
    int n_bad = 0;

    snitch_acc_share_arbiter #(.NrCores(4), .MaxOutstanding(2)) dut (
        .clk_i(clk), .rst_i(rst),
        .core_qvalid_i(core_qvalid), .core_qready_o(core_qready), .core_qdata_i(core_qdata),
        .acc_qvalid_o(acc_qvalid), .acc_qready_i(acc_qready), .acc_qdata_o(acc_qdata),
        .acc_qsrc_o(acc_qsrc),
        .acc_pvalid_i(acc_pvalid), .acc_pready_o(acc_pready), .acc_pdata_i(acc_pdata),
        .acc_psrc_i(acc_psrc),
        .core_pvalid_o(core_pvalid), .core_pready_i(core_pready), .core_pdata_o(core_pdata),
        .err_o(err)
    );

    // Five cores give a 3-bit source index, so an out-of-range source can be driven.
    snitch_acc_share_arbiter #(.NrCores(5), .MaxOutstanding(2)) dut5 (
        .clk_i(clk), .rst_i(rst),
        .core_qvalid_i(x_core_qvalid), .core_qready_o(x_core_qready), .core_qdata_i(x_core_qdata),
        .acc_qvalid_o(x_acc_qvalid), .acc_qready_i(x_acc_qready), .acc_qdata_o(x_acc_qdata),
        .acc_qsrc_o(x_acc_qsrc),
        .acc_pvalid_i(x_acc_pvalid), .acc_pready_o(x_acc_pready), .acc_pdata_i(x_acc_pdata),
        .acc_psrc_i(x_acc_psrc),
        .core_pvalid_o(x_core_pvalid), .core_pready_i(x_core_pready), .core_pdata_o(x_core_pdata),
        .err_o(x_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int unsigned base);
        for (int k = 0; k < 4; k++) core_qdata[k] = 165'(base + k);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        core_qvalid = 4'hF;
        acc_qready = 1'b1;
        tick();
        n_cmp++; if (core_qready !== 4'b0000) begin n_bad++; $display("FAIL rst_qready got %b want 0000", core_qready); end
        tick();
        n_cmp++; if (acc_qvalid !== 1'b0) begin n_bad++; $display("FAIL rst_qvalid got %b want 0", acc_qvalid); end
        n_cmp++; if (acc_qdata !== 165'd0) begin n_bad++; $display("FAIL rst_qdata got %h want 0", acc_qdata); end
        n_cmp++; if (acc_qsrc !== 2'd0) begin n_bad++; $display("FAIL rst_qsrc got %0d want 0", acc_qsrc); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL rst_err got %b want 0", err); end
        n_cmp++; if (x_err !== 1'b0) begin n_bad++; $display("FAIL rst_err5 got %b want 0", x_err); end
        core_qvalid = 4'h0;
        rst = 1'b0;
    endtask

    task automatic test_round_robin();
        core_qvalid = 4'hF;
        acc_qready = 1'b1;
        core_pready = 4'hF;
        set_data(32'h1000);
        for (int n = 0; n < 8; n++) begin
            acc_pvalid = acc_qvalid;
            acc_psrc = acc_qsrc;
            #1;
            n_cmp++; if (core_qready !== 4'(1 << (n % 4))) begin n_bad++; $display("FAIL rr_grant n=%0d got %b want %b", n, core_qready, 4'(1 << (n % 4))); end
            tick();
            n_cmp++; if (acc_qvalid !== 1'b1) begin n_bad++; $display("FAIL rr_qvalid n=%0d got %b want 1", n, acc_qvalid); end
            n_cmp++; if (acc_qsrc !== 2'(n % 4)) begin n_bad++; $display("FAIL rr_qsrc n=%0d got %0d want %0d", n, acc_qsrc, n % 4); end
            n_cmp++; if (acc_qdata !== 165'(32'h1000 + n % 4)) begin n_bad++; $display("FAIL rr_qdata n=%0d got %h want %h", n, acc_qdata, 165'(32'h1000 + n % 4)); end
        end
        core_qvalid = 4'h0;
        acc_pvalid = acc_qvalid;
        acc_psrc = acc_qsrc;
        tick();
        acc_pvalid = 1'b0;
        n_cmp++; if (acc_qvalid !== 1'b0) begin n_bad++; $display("FAIL rr_drain got %b want 0", acc_qvalid); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL rr_err got %b want 0", err); end
    endtask

    task automatic test_credit_limit();
        core_qvalid = 4'b0100;
        acc_qready = 1'b1;
        core_pready = 4'hF;
        acc_pvalid = 1'b0;
        set_data(32'h2000);
        for (int n = 0; n < 4; n++) begin
            #1;
            n_cmp++; if (core_qready !== ((n < 2) ? 4'b0100 : 4'b0000)) begin n_bad++; $display("FAIL cred_grant n=%0d got %b want %b", n, core_qready, (n < 2) ? 4'b0100 : 4'b0000); end
            tick();
        end
        acc_pvalid = 1'b1;
        acc_psrc = 2'd2;
        acc_pdata = 38'h15A5A;
        core_pready = 4'b1011;
        #1;
        n_cmp++; if (acc_pready !== 1'b0) begin n_bad++; $display("FAIL cred_pready_lo got %b want 0", acc_pready); end
        n_cmp++; if (core_pvalid !== 4'b0100) begin n_bad++; $display("FAIL cred_pvalid got %b want 0100", core_pvalid); end
        n_cmp++; if (core_pdata[0] !== 38'h15A5A) begin n_bad++; $display("FAIL cred_pdata0 got %h want 15a5a", core_pdata[0]); end
        n_cmp++; if (core_pdata[3] !== 38'h15A5A) begin n_bad++; $display("FAIL cred_pdata3 got %h want 15a5a", core_pdata[3]); end
        tick();
        core_pready = 4'hF;
        #1;
        n_cmp++; if (acc_pready !== 1'b1) begin n_bad++; $display("FAIL cred_pready_hi got %b want 1", acc_pready); end
        n_cmp++; if (core_qready !== 4'b0000) begin n_bad++; $display("FAIL cred_stalled got %b want 0000", core_qready); end
        tick();
        acc_pvalid = 1'b0;
        #1;
        n_cmp++; if (core_qready !== 4'b0100) begin n_bad++; $display("FAIL cred_third got %b want 0100", core_qready); end
        tick();
        #1;
        n_cmp++; if (core_qready !== 4'b0000) begin n_bad++; $display("FAIL cred_full got %b want 0000", core_qready); end
        core_qvalid = 4'h0;
        acc_pvalid = 1'b1;
        acc_psrc = 2'd2;
        tick();
        tick();
        acc_pvalid = 1'b0;
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL cred_err got %b want 0", err); end
    endtask

    task automatic test_backpressure();
        set_data(32'h3000);
        core_qvalid = 4'b0011;
        acc_qready = 1'b0;
        #1;
        n_cmp++; if (core_qready !== 4'b0001) begin n_bad++; $display("FAIL bp_first got %b want 0001", core_qready); end
        tick();
        core_qdata[0] = 165'h0BAD;
        for (int n = 0; n < 5; n++) begin
            #1;
            n_cmp++; if (core_qready !== 4'b0000) begin n_bad++; $display("FAIL bp_nogrant n=%0d got %b want 0000", n, core_qready); end
            n_cmp++; if (acc_qvalid !== 1'b1 || acc_qsrc !== 2'd0) begin n_bad++; $display("FAIL bp_hold n=%0d got v=%b s=%0d want v=1 s=0", n, acc_qvalid, acc_qsrc); end
            n_cmp++; if (acc_qdata !== 165'(32'h3000)) begin n_bad++; $display("FAIL bp_data n=%0d got %h want 3000", n, acc_qdata); end
            tick();
        end
        acc_qready = 1'b1;
        #1;
        n_cmp++; if (core_qready !== 4'b0010) begin n_bad++; $display("FAIL bp_release got %b want 0010", core_qready); end
        tick();
        n_cmp++; if (acc_qsrc !== 2'd1 || acc_qdata !== 165'(32'h3001)) begin n_bad++; $display("FAIL bp_next got s=%0d d=%h want s=1 d=3001", acc_qsrc, acc_qdata); end
        core_qvalid = 4'h0;
        tick();
        acc_pvalid = 1'b1;
        acc_psrc = 2'd0;
        tick();
        acc_psrc = 2'd1;
        tick();
        acc_pvalid = 1'b0;
    endtask

    task automatic test_simultaneous();
        set_data(32'h4000);
        core_qvalid = 4'b0010;
        acc_qready = 1'b1;
        core_pready = 4'hF;
        #1;
        n_cmp++; if (core_qready !== 4'b0010) begin n_bad++; $display("FAIL sim_first got %b want 0010", core_qready); end
        tick();
        acc_pvalid = 1'b1;
        acc_psrc = 2'd1;
        #1;
        n_cmp++; if (core_qready !== 4'b0010) begin n_bad++; $display("FAIL sim_both_q got %b want 0010", core_qready); end
        n_cmp++; if (core_pvalid !== 4'b0010) begin n_bad++; $display("FAIL sim_both_p got %b want 0010", core_pvalid); end
        tick();
        acc_pvalid = 1'b0;
        #1;
        n_cmp++; if (core_qready !== 4'b0010) begin n_bad++; $display("FAIL sim_room got %b want 0010", core_qready); end
        tick();
        #1;
        n_cmp++; if (core_qready !== 4'b0000) begin n_bad++; $display("FAIL sim_full got %b want 0000", core_qready); end
        core_qvalid = 4'h0;
        tick();
        acc_pvalid = 1'b1;
        acc_psrc = 2'd1;
        tick();
        tick();
        acc_pvalid = 1'b0;
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL sim_err got %b want 0", err); end
    endtask

    task automatic test_errors();
        acc_pvalid = 1'b1;
        acc_psrc = 2'd3;
        core_pready = 4'hF;
        #1;
        n_cmp++; if (core_pvalid !== 4'b1000) begin n_bad++; $display("FAIL unsol_pvalid got %b want 1000", core_pvalid); end
        n_cmp++; if (acc_pready !== 1'b1) begin n_bad++; $display("FAIL unsol_pready got %b want 1", acc_pready); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL unsol_err_pre got %b want 0", err); end
        tick();
        acc_pvalid = 1'b0;
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL unsol_err got %b want 1", err); end
        core_qvalid = 4'b1000;
        for (int n = 0; n < 3; n++) begin
            #1;
            n_cmp++; if (core_qready !== ((n < 2) ? 4'b1000 : 4'b0000)) begin n_bad++; $display("FAIL unsol_credit n=%0d got %b want %b", n, core_qready, (n < 2) ? 4'b1000 : 4'b0000); end
            tick();
        end
        core_qvalid = 4'h0;
        tick();
        x_acc_pvalid = 1'b1;
        x_acc_psrc = 3'd5;
        x_core_pready = 5'b00000;
        #1;
        n_cmp++; if (x_acc_pready !== 1'b1) begin n_bad++; $display("FAIL badsrc_pready got %b want 1", x_acc_pready); end
        n_cmp++; if (x_core_pvalid !== 5'b00000) begin n_bad++; $display("FAIL badsrc_pvalid got %b want 00000", x_core_pvalid); end
        n_cmp++; if (x_err !== 1'b0) begin n_bad++; $display("FAIL badsrc_err_pre got %b want 0", x_err); end
        tick();
        x_acc_pvalid = 1'b0;
        n_cmp++; if (x_err !== 1'b1) begin n_bad++; $display("FAIL badsrc_err got %b want 1", x_err); end
        tick();
        n_cmp++; if (x_err !== 1'b1) begin n_bad++; $display("FAIL badsrc_sticky got %b want 1", x_err); end
    endtask

    task automatic test_mid_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL mr_err_clr got %b want 0", err); end
        set_data(32'h5000);
        core_qvalid = 4'b1011;
        acc_qready = 1'b1;
        #1;
        n_cmp++; if (core_qready !== 4'b0001) begin n_bad++; $display("FAIL mr_g0 got %b want 0001", core_qready); end
        tick();
        n_cmp++; if (core_qready !== 4'b0010) begin n_bad++; $display("FAIL mr_g1 got %b want 0010", core_qready); end
        tick();
        n_cmp++; if (core_qready !== 4'b1000) begin n_bad++; $display("FAIL mr_g3 got %b want 1000", core_qready); end
        tick();
        core_qvalid = 4'b0001;
        #1;
        n_cmp++; if (core_qready !== 4'b0001) begin n_bad++; $display("FAIL mr_g0b got %b want 0001", core_qready); end
        tick();
        n_cmp++; if (acc_qvalid !== 1'b1 || acc_qsrc !== 2'd0) begin n_bad++; $display("FAIL mr_full got v=%b s=%0d want v=1 s=0", acc_qvalid, acc_qsrc); end
        acc_qready = 1'b0;
        rst = 1'b1;
        core_qvalid = 4'hF;
        #1;
        n_cmp++; if (core_qready !== 4'b0000) begin n_bad++; $display("FAIL mr_rst_qready got %b want 0000", core_qready); end
        tick();
        rst = 1'b0;
        n_cmp++; if (acc_qvalid !== 1'b0 || acc_qsrc !== 2'd0 || acc_qdata !== 165'd0) begin n_bad++; $display("FAIL mr_cleared got v=%b s=%0d d=%h want 0", acc_qvalid, acc_qsrc, acc_qdata); end
        acc_qready = 1'b1;
        #1;
        n_cmp++; if (core_qready !== 4'b0001) begin n_bad++; $display("FAIL mr_prio got %b want 0001", core_qready); end
        tick();
        core_qvalid = 4'b0001;
        #1;
        n_cmp++; if (core_qready !== 4'b0001) begin n_bad++; $display("FAIL mr_c0_room got %b want 0001", core_qready); end
        tick();
        n_cmp++; if (core_qready !== 4'b0000) begin n_bad++; $display("FAIL mr_c0_full got %b want 0000", core_qready); end
        core_qvalid = 4'h0;
        tick();
    endtask

    initial begin
        rst = 1'b1;
        core_qvalid = '0;
        core_qdata = '0;
        acc_qready = 1'b0;
        acc_pvalid = 1'b0;
        acc_pdata = '0;
        acc_psrc = '0;
        core_pready = '0;
        x_core_qvalid = '0;
        x_core_qdata = '0;
        x_acc_qready = 1'b0;
        x_acc_pvalid = 1'b0;
        x_acc_pdata = '0;
        x_acc_psrc = '0;
        x_core_pready = '0;

        test_reset();
        test_round_robin();
        test_credit_limit();
        test_backpressure();
        test_simultaneous();
        test_errors();
        test_mid_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
